// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the boot-time program loader.
//   loader_state_e : loader FSM states
//   INSTR_W        : instruction word width (fixed at 9)
//   HI_RSVD_MASK   : bits of the HI byte that must be zero
package loader_pkg;

    localparam int INSTR_W = 9;

    // Only bit 0 of the HI byte carries instruction data.
    localparam logic [7:0] HI_RSVD_MASK = 8'hFE;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_e;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: fills the instruction memory from a byte stream at boot and
// holds the CPU in reset until the image has been loaded and its checksum
// verified.
//
// Stream: count byte N (0 means 2^IW), N pairs {LO, HI}, checksum byte.
// The checksum is the XOR of the count byte and every payload byte.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high
//   in_valid   in   stream byte present on in_data
//   in_data    in   stream byte
//   in_ready   out  loader accepts a byte (registered)
//   wr_en      out  one-cycle instruction-memory write strobe
//   wr_addr    out  write address
//   wr_data    out  9-bit instruction word
//   cpu_hold   out  CPU reset; released only after a good load
//   load_done  out  sticky, good checksum seen
//   err        out  sticky, format or checksum error
//
// State  | meaning
// -------+-------------------------------------------------------------
// LEN    | waiting for the count byte
// LO     | waiting for the low byte of an instruction
// HI     | waiting for the high byte; issues the memory write
// CSUM   | waiting for the checksum byte
// DONE   | load good, CPU released, no more bytes accepted
// ERR    | load failed, CPU held, no more bytes accepted
module prog_loader
    import loader_pkg::*;
#(
    parameter int IW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               wr_en,
    output logic [IW-1:0]      wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               err
);

    // A count byte of zero means a full memory image.
    localparam logic [IW:0] FULL_COUNT = {1'b1, {IW{1'b0}}};

    loader_state_e      state_q, state_d;
    logic [IW:0]        remaining_q, remaining_d;
    logic [7:0]         chk_q, chk_d;
    logic [IW-1:0]      addr_q, addr_d;
    logic [7:0]         stash_q, stash_d;

    logic               in_ready_q, in_ready_d;
    logic               wr_en_q, wr_en_d;
    logic [IW-1:0]      wr_addr_q, wr_addr_d;
    logic [INSTR_W-1:0] wr_data_q, wr_data_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               load_done_q, load_done_d;
    logic               err_q, err_d;

    logic               accept;

    // in_ready is a flop, so a transfer is judged against its registered value.
    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        chk_d       = chk_q;
        addr_d      = addr_q;
        stash_d     = stash_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        case (state_q)
            ST_LEN: begin
                if (accept) begin
                    remaining_d = (in_data == 8'd0) ? FULL_COUNT : (IW+1)'(in_data);
                    chk_d       = in_data;
                    addr_d      = '0;
                    state_d     = ST_LO;
                end
            end
            ST_LO: begin
                if (accept) begin
                    stash_d = in_data;
                    chk_d   = chk_q ^ in_data;
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (accept) begin
                    if ((in_data & HI_RSVD_MASK) != 8'd0) begin
                        state_d = ST_ERR;
                    end else begin
                        chk_d       = chk_q ^ in_data;
                        wr_en_d     = 1'b1;
                        wr_addr_d   = addr_q;
                        wr_data_d   = {in_data[0], stash_q};
                        // Wraps to 0 after the last write of a full image;
                        // harmless because the FSM leaves the load loop.
                        addr_d      = addr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        state_d     = (remaining_q == (IW+1)'(1)) ? ST_CSUM : ST_LO;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (in_data == chk_q) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase

        // Status outputs follow the next state so they change on the same
        // edge that moves the FSM.
        in_ready_d  = (state_d == ST_LEN) || (state_d == ST_LO) ||
                      (state_d == ST_HI)  || (state_d == ST_CSUM);
        cpu_hold_d  = (state_d != ST_DONE);
        load_done_d = (state_d == ST_DONE);
        err_d       = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_LEN;
            remaining_q <= '0;
            chk_q       <= '0;
            addr_q      <= '0;
            stash_q     <= '0;
            in_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            chk_q       <= chk_d;
            addr_q      <= addr_d;
            stash_q     <= stash_d;
            in_ready_q  <= in_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign err       = err_q;

endmodule
